// File: rtl/mandel_scheduler.sv
// Mandelbrot frame scheduler: walks the pixel raster, dispatches pixels to NUM_ENG iterator
// engines and streams results out. Optional frame cycle counter: define CYCLE_COUNT_EN.
module mandel_scheduler #(
    parameter int NUM_ENG = 4,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [26:0]           x_start,
    input  logic [26:0]           y_start,
    input  logic [26:0]           dx,
    input  logic [26:0]           dy,
    input  logic [11:0]           max_iter,
    output logic [NUM_ENG-1:0]    eng_start,
    output logic [26:0]           eng_cr,
    output logic [26:0]           eng_ci,
    output logic [11:0]           eng_max_iter,
    input  logic [NUM_ENG-1:0]    eng_done,
    input  logic [12*NUM_ENG-1:0] eng_iter,
    output logic                  pix_valid,
    output logic [9:0]            pix_x,
    output logic [8:0]            pix_y,
    output logic [11:0]           pix_iter,
    input  logic                  pix_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic [31:0]           frame_cycles
);

    localparam int SW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef enum logic [1:0] {SLOT_IDLE, SLOT_BUSY, SLOT_RESULT} slot_t;

    state_t state, state_next;

    slot_t       slot_st   [NUM_ENG];
    logic [9:0]  slot_x    [NUM_ENG];
    logic [8:0]  slot_y    [NUM_ENG];
    logic [11:0] slot_iter [NUM_ENG];

    logic signed [26:0] x0, dx_l, dy_l, cr, ci;
    logic [11:0]        mi;
    logic [9:0]         cur_x;
    logic [8:0]         cur_y;

    logic          disp_any, dispatch;
    logic [SW-1:0] disp_idx;
    logic          grant_any, can_grant;
    logic [SW-1:0] grant_idx, last_grant, out_slot;
    logic          accept, all_idle, last_pix, start_ok;

    assign accept   = pix_valid && pix_ready;
    assign last_pix = (cur_x == X_LAST) && (cur_y == Y_LAST);
    assign start_ok = (state == IDLE) && start;
    assign busy       = (state == RUN) || (state == DRAIN);
    assign frame_done = (state == DONE);

    assign eng_cr       = cr;
    assign eng_ci       = ci;
    assign eng_max_iter = mi;

    // Lowest-index idle slot wins, judged on registered slot state only.
    always_comb begin
        disp_any = 1'b0;
        disp_idx = '0;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (slot_st[i] == SLOT_IDLE) begin
                disp_any = 1'b1;
                disp_idx = SW'(i);
            end
        end
        dispatch  = (state == RUN) && disp_any;
        eng_start = '0;
        if (dispatch) eng_start[disp_idx] = 1'b1;
    end

    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (slot_st[i] != SLOT_IDLE) all_idle = 1'b0;
        end
    end

    // Round-robin grant; the slot currently on pix_* is still RESULT and must be skipped.
    always_comb begin
        int            cand;
        logic [SW-1:0] cidx;
        cand      = 0;
        cidx      = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        can_grant = busy && (!pix_valid || pix_ready);
        for (int k = 1; k <= NUM_ENG; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_ENG) cand = cand - NUM_ENG;
            cidx = SW'(cand);
            if (can_grant && !grant_any && slot_st[cidx] == SLOT_RESULT &&
                !(pix_valid && out_slot == cidx)) begin
                grant_any = 1'b1;
                grant_idx = cidx;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (dispatch && last_pix) state_next = DRAIN;
            DRAIN:   if (all_idle && !pix_valid) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Frame operands are latched once; cr/ci advance incrementally along the raster.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x0    <= '0;
            dx_l  <= '0;
            dy_l  <= '0;
            cr    <= '0;
            ci    <= '0;
            mi    <= '0;
            cur_x <= '0;
            cur_y <= '0;
        end else if (start_ok) begin
            x0    <= x_start;
            dx_l  <= dx;
            dy_l  <= dy;
            cr    <= x_start;
            ci    <= y_start;
            mi    <= max_iter;
            cur_x <= '0;
            cur_y <= '0;
        end else if (dispatch) begin
            if (cur_x == X_LAST) begin
                cur_x <= '0;
                cur_y <= cur_y + 9'd1;
                cr    <= x0;
                ci    <= ci + dy_l;
            end else begin
                cur_x <= cur_x + 10'd1;
                cr    <= cr + dx_l;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENG; i++) begin
                slot_st[i]   <= SLOT_IDLE;
                slot_x[i]    <= '0;
                slot_y[i]    <= '0;
                slot_iter[i] <= '0;
            end
            last_grant <= '0;
            out_slot   <= '0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_iter   <= '0;
        end else begin
            for (int i = 0; i < NUM_ENG; i++) begin
                case (slot_st[i])
                    SLOT_IDLE: if (dispatch && disp_idx == SW'(i)) begin
                        slot_st[i] <= SLOT_BUSY;
                        slot_x[i]  <= cur_x;
                        slot_y[i]  <= cur_y;
                    end
                    SLOT_BUSY: if (eng_done[i]) begin
                        slot_st[i]   <= SLOT_RESULT;
                        slot_iter[i] <= eng_iter[i*12 +: 12];
                    end
                    SLOT_RESULT: if (accept && out_slot == SW'(i)) slot_st[i] <= SLOT_IDLE;
                    default: slot_st[i] <= SLOT_IDLE;
                endcase
            end
            if (grant_any) begin
                pix_valid  <= 1'b1;
                pix_x      <= slot_x[grant_idx];
                pix_y      <= slot_y[grant_idx];
                pix_iter   <= slot_iter[grant_idx];
                out_slot   <= grant_idx;
                last_grant <= grant_idx;
            end else if (accept) begin
                pix_valid <= 1'b0;
            end
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc_cnt      <= '0;
            frame_cycles <= '0;
        end else begin
            if (start_ok)  cyc_cnt <= '0;
            else if (busy) cyc_cnt <= cyc_cnt + 32'd1;
            if (state == DONE) frame_cycles <= cyc_cnt;
        end
    end
`else
    assign frame_cycles = '0;
`endif

endmodule

// File: tb/tb_mandel_scheduler.sv
// Randomized bench for mandel_scheduler: engine models, raster reference for operands,
// per-pixel scoreboard of the output stream.
module tb_mandel_scheduler;

    localparam int NE   = 2;
    localparam int H    = 4;
    localparam int V    = 2;
    localparam int NPIX = H * V;

    logic clock = 1'b0, reset = 1'b0, start = 1'b0;
    logic [26:0] x_start = '0, y_start = '0, dx = '0, dy = '0;
    logic [11:0] max_iter = '0;
    logic [NE-1:0] eng_start;
    logic [26:0] eng_cr, eng_ci;
    logic [11:0] eng_max_iter;
    logic [NE-1:0] eng_done = '0;
    logic [12*NE-1:0] eng_iter = '0;
    logic pix_valid, pix_ready = 1'b1;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [11:0] pix_iter;
    logic busy, frame_done;
    logic [31:0] frame_cycles;

    mandel_scheduler #(.NUM_ENG(NE), .H_RES(H), .V_RES(V)) dut (
        .clock(clock), .reset(reset), .start(start),
        .x_start(x_start), .y_start(y_start), .dx(dx), .dy(dy), .max_iter(max_iter),
        .eng_start(eng_start), .eng_cr(eng_cr), .eng_ci(eng_ci), .eng_max_iter(eng_max_iter),
        .eng_done(eng_done), .eng_iter(eng_iter),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_iter(pix_iter),
        .pix_ready(pix_ready), .busy(busy), .frame_done(frame_done), .frame_cycles(frame_cycles)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Frame reference: pixel (x,y) has c = start + index*step, computed directly.
    logic signed [26:0] f_xs, f_ys, f_dx, f_dy;
    logic [11:0] f_mi;
    bit f_const = 0, iter_const = 0;

    function automatic logic [26:0] model_cr(int x);
        longint t;
        t = longint'(f_xs) + longint'(x) * longint'(f_dx);
        return t[26:0];
    endfunction

    function automatic logic [26:0] model_ci(int y);
        longint t;
        t = longint'(f_ys) + longint'(y) * longint'(f_dy);
        return t[26:0];
    endfunction

    function automatic logic [11:0] hash(logic [26:0] cr, logic [26:0] ci, logic [11:0] m);
        return cr[11:0] ^ cr[26:15] ^ ci[11:0] ^ ci[22:11] ^ m;
    endfunction

    function automatic logic [11:0] exp_iter(int x, int y);
        return f_const ? 12'd5 : hash(model_cr(x), model_ci(y), f_mi);
    endfunction

    // Engine models: fixed latency per engine, or random 1..8 when lat_fixed is 0.
    int lat_fixed [NE];
    int e_cnt [NE];
    bit e_busy [NE];
    bit overlap_seen;

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                for (int e = 0; e < NE; e++) e_busy[e] = 0;
                eng_done = '0;
            end else begin
                if (eng_start[0] && e_busy[1]) overlap_seen = 1;
                for (int e = 0; e < NE; e++) begin
                    if (eng_start[e]) begin
                        eng_done[e] = 1'b0;
                        e_busy[e] = 1;
                        e_cnt[e] = (lat_fixed[e] != 0) ? lat_fixed[e] : int'($urandom_range(1, 8));
                        eng_iter[e*12 +: 12] = iter_const ? 12'd5 : hash(eng_cr, eng_ci, eng_max_iter);
                    end else if (e_busy[e]) begin
                        e_cnt[e]--;
                        if (e_cnt[e] == 0) begin
                            e_busy[e] = 0;
                            eng_done[e] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    int ready_mode = 1;
    initial begin
        forever begin
            @(posedge clock);
            #1;
            pix_ready = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
        end
    end

    int disp_k, acc_cnt, fd_cnt, busy_cycles;
    bit seen [NPIX];
    bit order_differs, prev_stall;
    logic [9:0] prev_x;
    logic [8:0] prev_y;
    logic [11:0] prev_iter;
    logic [26:0] cap_cr, cap_ci;

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                if (busy) busy_cycles++;
                if (frame_done) fd_cnt++;
                if (eng_start != '0) begin
                    chk("disp_onehot", $countones(eng_start), 1);
                    chk("disp_in_frame", disp_k < NPIX, 1);
                    if (disp_k < NPIX) begin
                        chk("disp_cr", eng_cr, model_cr(disp_k % H));
                        chk("disp_ci", eng_ci, model_ci(disp_k / H));
                        chk("disp_mi", eng_max_iter, f_mi);
                        if (disp_k == 7) begin
                            cap_cr = eng_cr;
                            cap_ci = eng_ci;
                        end
                    end
                    disp_k++;
                end
                if (prev_stall) begin
                    chk("hold_valid", pix_valid, 1);
                    chk("hold_x", pix_x, prev_x);
                    chk("hold_y", pix_y, prev_y);
                    chk("hold_iter", pix_iter, prev_iter);
                end
                if (pix_valid && pix_ready) begin
                    chk("pix_in_range", (pix_x < H) && (pix_y < V), 1);
                    if (pix_x < H && pix_y < V) begin
                        chk("pix_unique", seen[pix_y*H + pix_x], 0);
                        seen[pix_y*H + pix_x] = 1;
                        chk("pix_iter", pix_iter, exp_iter(pix_x, pix_y));
                        if (pix_y*H + pix_x != acc_cnt) order_differs = 1;
                    end
                    acc_cnt++;
                end
                prev_stall = pix_valid && !pix_ready;
                prev_x = pix_x;
                prev_y = pix_y;
                prev_iter = pix_iter;
            end
        end
    end

    task automatic clear_frame();
        disp_k = 0; acc_cnt = 0; fd_cnt = 0; busy_cycles = 0;
        order_differs = 0; prev_stall = 0; overlap_seen = 0;
        for (int i = 0; i < NPIX; i++) seen[i] = 0;
    endtask

    task automatic do_start(input logic [26:0] xs, input logic [26:0] ys,
                            input logic [26:0] sx, input logic [26:0] sy, input logic [11:0] m);
        f_xs = xs; f_ys = ys; f_dx = sx; f_dy = sy; f_mi = m;
        @(posedge clock); #1;
        x_start = xs; y_start = ys; dx = sx; dy = sy; max_iter = m;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic pulse_garbage_start();
        @(posedge clock); #1;
        x_start = 27'($urandom); y_start = 27'($urandom);
        dx = 27'($urandom); dy = 27'($urandom); max_iter = 12'($urandom);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        for (int i = 0; i < budget && fd_cnt == 0; i++) @(negedge clock);
        repeat (3) @(negedge clock);
        chk("frame_done_once", fd_cnt, 1);
        chk("pix_count", acc_cnt, NPIX);
`ifdef CYCLE_COUNT_EN
        chk("frame_cycles", frame_cycles, busy_cycles);
`else
        chk("frame_cycles", frame_cycles, 0);
`endif
    endtask

    task automatic rand_frame();
        do_start(27'($urandom), 27'($urandom), 27'($urandom), 27'($urandom), 12'($urandom));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_eng_start"}, eng_start, 0);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_frame_cycles"}, frame_cycles, 0);
    endtask

    initial begin
        int d0;
        lat_fixed[0] = 3; lat_fixed[1] = 3;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        @(posedge clock); #1;
        reset = 1'b1;

        // Fixed-latency engines returning a constant count.
        iter_const = 1; f_const = 1; ready_mode = 1;
        clear_frame();
        rand_frame();
        wait_frame(500);

        // Known operands: pixel (3,1) must see cr=-1.25, ci=0.5.
        iter_const = 0; f_const = 0; ready_mode = 2;
        lat_fixed[0] = 0; lat_fixed[1] = 0;
        clear_frame();
        do_start(27'h7000000, 27'h0800000, 27'h0200000, 27'h7C00000, 12'd100);
        wait_frame(1000);
        chk("cr_at_3_1", cap_cr, 27'h7600000);
        chk("ci_at_3_1", cap_ci, 27'h0400000);

        // Downstream stall while both engines hold results.
        lat_fixed[0] = 2; lat_fixed[1] = 2; ready_mode = 0;
        clear_frame();
        rand_frame();
        for (int i = 0; i < 100 && eng_done != 2'b11; i++) @(negedge clock);
        chk("stall_setup", eng_done, 2'b11);
        repeat (2) @(negedge clock);
        d0 = disp_k;
        repeat (10) @(negedge clock);
        chk("stall_no_dispatch", disp_k, d0);
        chk("stall_no_accept", acc_cnt, 0);
        ready_mode = 1;
        wait_frame(1000);

        // Fast engine 0, slow engine 1.
        lat_fixed[0] = 1; lat_fixed[1] = 50;
        clear_frame();
        rand_frame();
        wait_frame(2000);
        chk("redispatch_while_busy", overlap_seen, 1);
        chk("out_of_raster_order", order_differs, 1);

        lat_fixed[0] = 0; lat_fixed[1] = 0; ready_mode = 2;
        for (int f = 0; f < 4; f++) begin
            clear_frame();
            rand_frame();
            wait_frame(1000);
        end

        // Start during RUN must not disturb the frame.
        ready_mode = 1;
        clear_frame();
        rand_frame();
        pulse_garbage_start();
        wait_frame(1000);

        // Reset mid-frame aborts without frame_done; next frame is complete.
        clear_frame();
        rand_frame();
        repeat (4) @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_outputs_zero("abort");
        repeat (3) @(negedge clock);
        chk("abort_no_frame_done", fd_cnt, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        clear_frame();
        rand_frame();
        wait_frame(1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
